fft_twiddle_mult: RTL and testbench

- Streaming complex-multiply stage that sits directly downstream of the FFT twiddle ROM pair (real ROM and imaginary ROM).
- Generates the shared ROM address for each accepted sample and aligns the sample with the ROM's registered 1-cycle read data.
- Multiplies sample by twiddle and emits a rounded, saturated complex result with valid/ready flow control.
- Feeds the next butterfly stage of the CWT FFT path.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/fft_cmul_round_sat.sv | 64 ++++++
 rtl/fft_twiddle_mult.sv | 119 +++++++++++
 tb/tb_fft_twiddle_mult.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the CWT FFT datapath: widths, twiddle format,
// saturation bounds, complex sample type and the round/saturate helper.
package fft_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned TW_W     = 16;
  localparam int unsigned TW_FRAC  = 8;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned TW_DEPTH = 28;

  // Full-precision product and sum widths
  localparam int unsigned PROD_W = DATA_W + TW_W;
  localparam int unsigned SUM_W  = PROD_W + 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Half an output LSB at twiddle scale, for round half-up
  localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1) << (TW_FRAC - 1);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Round half-up, drop the twiddle fraction, clamp to the sample range
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] r;
    r = (v + RND_HALF) >>> TW_FRAC;
    if (r > SUM_W'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (r < SUM_W'(SAT_MIN)) begin
      return SAT_MIN;
    end
    return DATA_W'(r);
  endfunction

endpackage

// File: rtl/fft_cmul_round_sat.sv
// Registered 4-multiplier complex product stage with combinational
// add / round half-up / saturate on the registered products.
// Ports: clk, rst (sync, active-high), en (stage advance), in_valid/in_last
// with sample a and twiddle c + jd; out_valid/out_last registered with the
// products; res_c is the combinational rounded, saturated result.
module fft_cmul_round_sat
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  cplx_t                  a,
  input  logic signed [TW_W-1:0] c,
  input  logic signed [TW_W-1:0] d,
  output logic                   out_valid,
  output logic                   out_last,
  output cplx_t                  res_c
);

  logic signed [DATA_W-1:0] a_re;
  logic signed [DATA_W-1:0] a_im;
  logic signed [PROD_W-1:0] p_ac;
  logic signed [PROD_W-1:0] p_bd;
  logic signed [PROD_W-1:0] p_ad;
  logic signed [PROD_W-1:0] p_bc;
  logic signed [SUM_W-1:0]  sum_re;
  logic signed [SUM_W-1:0]  sum_im;

  assign a_re = a.re;
  assign a_im = a.im;

  // Product registers; only loaded for real samples
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      p_ac      <= '0;
      p_bd      <= '0;
      p_ad      <= '0;
      p_bc      <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_last <= in_last;
        p_ac     <= PROD_W'(a_re) * PROD_W'(c);
        p_bd     <= PROD_W'(a_im) * PROD_W'(d);
        p_ad     <= PROD_W'(a_re) * PROD_W'(d);
        p_bc     <= PROD_W'(a_im) * PROD_W'(c);
      end
    end
  end

  // (a+jb)(c+jd): real = ac - bd, imag = ad + bc
  always_comb begin
    sum_re   = SUM_W'(p_ac) - SUM_W'(p_bd);
    sum_im   = SUM_W'(p_ad) + SUM_W'(p_bc);
    res_c    = '0;
    res_c.re = round_sat(sum_re);
    res_c.im = round_sat(sum_im);
  end

endmodule

// File: rtl/fft_twiddle_mult.sv
// Streaming twiddle multiply stage behind the twiddle ROM pair.
// Generates the shared ROM address per accepted sample, aligns the sample
// with the ROM's 1-cycle registered data, and emits the rounded, saturated
// complex product with valid/ready flow control (3 register stages).
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_re/in_im/in_last
// upstream; rom_addr/tw_re/tw_im to the ROMs; out_valid/out_ready/out_re/
// out_im/out_last downstream.
module fft_twiddle_mult
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     in_last,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_last
);

  logic              en;
  logic              accept;
  logic [ADDR_W-1:0] addr_cnt;

  logic              s1_valid;
  logic              s1_last;
  logic [ADDR_W-1:0] s1_addr;
  cplx_t             s1_smp;

  logic              s2_valid;
  logic              s2_last;
  cplx_t             s2_res_c;

  // Whole pipeline advances together whenever the output slot can move
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // While stalled, re-present S1's address so the ROM keeps its twiddle aligned
  always_comb begin
    rom_addr = addr_cnt;
    if (rst) begin
      rom_addr = '0;
    end else if (!en) begin
      rom_addr = s1_addr;
    end
  end

  // Twiddle index; a frame end restarts the sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (accept) begin
      if (in_last || addr_cnt == ADDR_W'(TW_DEPTH - 1)) begin
        addr_cnt <= '0;
      end else begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end
    end
  end

  // S1: sample waiting for its twiddle from the ROM
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_smp   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last   <= in_last;
        s1_addr   <= addr_cnt;
        s1_smp.re <= in_re;
        s1_smp.im <= in_im;
      end
    end
  end

  // S2: products
  fft_cmul_round_sat u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (s1_valid),
    .in_last   (s1_last),
    .a         (s1_smp),
    .c         (tw_re),
    .d         (tw_im),
    .out_valid (s2_valid),
    .out_last  (s2_last),
    .res_c     (s2_res_c)
  );

  // S3: output registers, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_re   <= s2_res_c.re;
        out_im   <= s2_res_c.im;
        out_last <= s2_last;
      end
    end
  end

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Bench for fft_twiddle_mult: twiddle ROM model, directed vectors, a
// cycle-level reference model and a per-cycle compare process.
module tb_fft_twiddle_mult;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic               in_last = 1'b0;
  logic [4:0]         rom_addr;
  logic signed [15:0] tw_re = '0;
  logic signed [15:0] tw_im = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic               out_last;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  fft_twiddle_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .rom_addr  (rom_addr),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
  );

  // Twiddle ROM pair: registered read, data one cycle after the address
  logic signed [15:0] rom_re [28];
  logic signed [15:0] rom_im [28];

  always @(posedge clk) begin
    if (rom_addr < 5'd28) begin
      tw_re <= rom_re[rom_addr];
      tw_im <= rom_im[rom_addr];
    end else begin
      tw_re <= '0;
      tw_im <= '0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Complex multiply in Q8 twiddle format, round half-up, saturate
  function automatic void cmul(input longint a, input longint b, input longint c, input longint d,
                               output int re, output int im);
    longint r;
    longint i;
    r  = a * c - b * d;
    i  = a * d + b * c;
    re = clamp16((r + 128) >>> 8);
    im = clamp16((i + 128) >>> 8);
  endfunction

  // Reference model: three in-order slots, advancing while the last slot is free or drained
  typedef struct {
    bit v;
    int re;
    int im;
    bit last;
    int addr;
  } slot_t;

  slot_t m[3];
  int    m_addr = 0;

  always @(posedge clk) begin : model
    bit en_m;
    int rv;
    int iv;
    if (rst) begin
      for (int k = 0; k < 3; k++) m[k] = '{0, 0, 0, 0, 0};
      m_addr = 0;
    end else begin
      en_m = !m[2].v || out_ready;
      if (en_m) begin
        m[2]   = m[1];
        m[1]   = m[0];
        m[0].v = in_valid;
        if (in_valid) begin
          cmul(longint'(in_re), longint'(in_im), longint'(rom_re[m_addr]), longint'(rom_im[m_addr]), rv, iv);
          m[0] = '{1, rv, iv, in_last, m_addr};
          m_addr = (in_last || m_addr == 27) ? 0 : m_addr + 1;
        end
      end
    end
  end

  typedef struct {
    int re;
    int im;
    bit last;
  } obs_t;
  obs_t obs[$];

  bit                 prev_stall = 1'b0;
  logic signed [15:0] prev_re, prev_im;
  logic               prev_last;

  // Per-cycle compare against the model, plus stall stability and transfer log
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      bit exp_en;
      exp_en = !m[2].v || out_ready;
      chk("out_valid", out_valid, m[2].v);
      if (m[2].v) begin
        chk("out_re", out_re, m[2].re);
        chk("out_im", out_im, m[2].im);
        chk("out_last", out_last, m[2].last);
      end
      chk("in_ready", in_ready, exp_en);
      if (rst) chk("rom_addr_rst", rom_addr, 0);
      else if (exp_en) chk("rom_addr", rom_addr, m_addr);
      else if (m[0].v) chk("rom_addr_hold", rom_addr, m[0].addr);
      if (prev_stall) begin
        chk("stall_re", out_re, prev_re);
        chk("stall_im", out_im, prev_im);
        chk("stall_last", out_last, prev_last);
      end
      if (!rst && out_valid && out_ready)
        obs.push_back('{int'(out_re), int'(out_im), out_last});
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_re    = out_re;
    prev_im    = out_im;
    prev_last  = out_last;
  end

  always @(negedge clk) begin
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Present one sample and wait (bounded) for it to be accepted; returns its ROM address
  task automatic send(input int re, input int im, input bit last, output int addr_seen);
    bit got;
    got = 1'b0;
    addr_seen = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = 16'(re);
    in_im    = 16'(im);
    in_last  = last;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (in_ready) begin
        addr_seen = int'(rom_addr);
        got = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a;
    int r;
    int i;

    for (int k = 0; k < 28; k++) begin
      rom_re[k] = 16'($urandom);
      rom_im[k] = 16'($urandom);
    end
    rom_re[0] = 16'h0000; rom_im[0] = 16'hFF00;
    rom_re[1] = 16'h00B6; rom_im[1] = 16'hFF4A;
    rom_re[2] = 16'hFF00; rom_im[2] = 16'hFF00;
    rom_re[3] = 16'h0100; rom_im[3] = 16'h0000;

    // Model pinned to hand-computed values
    cmul(1000, 1000, 182, -182, r, i);
    chk("model_re_1422", r, 1422);
    chk("model_im_0", i, 0);
    cmul(-32768, -32768, -256, -256, r, i);
    chk("model_re_0", r, 0);
    chk("model_im_sat", i, 32767);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_rom_addr", rom_addr, 0);
    chk_on = 1'b1;

    // Directed products and latency of the first sample
    send(1000, 0, 1'b0, a);
    chk("addr_s0", a, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("lat_edge1", out_valid, 0);
    @(negedge clk);
    #2;
    chk("lat_edge2", out_valid, 0);
    @(negedge clk);
    #2;
    chk("lat_edge3", out_valid, 1);
    send(1000, 1000, 1'b0, a);
    chk("addr_s1", a, 1);
    send(-32768, -32768, 1'b0, a);
    chk("addr_s2", a, 2);
    send(32767, 0, 1'b1, a);
    chk("addr_s3", a, 3);
    idle(6);
    chk("dir_count", obs.size(), 4);
    chk("dir0_re", obs[0].re, 0);
    chk("dir0_im", obs[0].im, -1000);
    chk("dir1_re", obs[1].re, 1422);
    chk("dir1_im", obs[1].im, 0);
    chk("dir2_re", obs[2].re, 0);
    chk("dir2_im", obs[2].im, 32767);
    chk("dir3_re", obs[3].re, 32767);
    chk("dir3_im", obs[3].im, 0);
    chk("dir3_last", obs[3].last, 1);

    // Address wrap over 30 samples
    do_reset();
    for (int k = 0; k < 30; k++) begin
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 1'b0, a);
      chk("wrap_addr", a, k % 28);
    end
    idle(5);

    // Frame end on the 5th sample restarts the address
    do_reset();
    for (int k = 0; k < 7; k++) begin
      send(k * 100, -k * 50, k == 4, a);
      chk("last_addr", a, (k < 5) ? k : k - 5);
    end
    idle(5);

    // Frame end on the final table entry behaves like a wrap
    do_reset();
    for (int k = 0; k < 29; k++) begin
      send(k * 7, k * 3, k == 27, a);
      chk("last27_addr", a, (k < 28) ? k : 0);
    end
    idle(5);

    // Random backpressure with a reset mid-stream
    do_reset();
    rand_rdy = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (k == 50) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        rst = 1'b0;
        send(1234, -4321, 1'b0, a);
        chk("midrst_first_addr", a, 0);
      end
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 7) == 0, a);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    idle(10);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
